// File: rtl/clock_pkg.sv
// Shared types, limits and field arithmetic for the time-setting front panel.
package clock_pkg;

    localparam int MAX_HOURS   = 23;
    localparam int MAX_MINUTES = 59;
    localparam int HRS_W       = 5;
    localparam int MIN_W       = 7;

    typedef enum logic [1:0] {
        RUN,
        EDIT_HRS,
        EDIT_MIN,
        COMMIT
    } state_t;

    // Simultaneous up and down cancel out; wrap is by compare against the field maximum.
    function automatic logic [HRS_W-1:0] step_hours(input logic [HRS_W-1:0] v,
                                                    input logic up, input logic dn);
        logic [HRS_W-1:0] r;
        r = v;
        if (up && !dn)
            r = (v == HRS_W'(MAX_HOURS)) ? '0 : v + 1'b1;
        else if (dn && !up)
            r = (v == '0) ? HRS_W'(MAX_HOURS) : v - 1'b1;
        return r;
    endfunction

    function automatic logic [MIN_W-1:0] step_minutes(input logic [MIN_W-1:0] v,
                                                      input logic up, input logic dn);
        logic [MIN_W-1:0] r;
        r = v;
        if (up && !dn)
            r = (v == MIN_W'(MAX_MINUTES)) ? '0 : v + 1'b1;
        else if (dn && !up)
            r = (v == '0) ? MIN_W'(MAX_MINUTES) : v - 1'b1;
        return r;
    endfunction

    function automatic logic [HRS_W-1:0] clamp_hours(input logic [HRS_W-1:0] v);
        return (v > HRS_W'(MAX_HOURS)) ? '0 : v;
    endfunction

    function automatic logic [MIN_W-1:0] clamp_minutes(input logic [MIN_W-1:0] v);
        return (v > MIN_W'(MAX_MINUTES)) ? '0 : v;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the accepted rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CNT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count holds the number of consecutive samples that disagree with the accepted level.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/time_set_controller.sv
// Front-panel time-setting FSM: edits a shadow copy of the current time with
// debounced mode/inc/dec buttons and commits it with a held set strobe.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CNT  = 1000,
    parameter int REPEAT_DELAY  = 50000,
    parameter int REPEAT_PERIOD = 10000,
    parameter int SET_HOLD      = 100000,
    parameter int TIMEOUT       = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic [HRS_W-1:0] cur_hours,
    input  logic [MIN_W-1:0] cur_minutes,
    output logic             set,
    output logic [HRS_W-1:0] set_hours,
    output logic [MIN_W-1:0] set_minutes,
    output logic             edit_hrs,
    output logic             edit_min
);

    localparam int RPT_W  = $clog2(REPEAT_DELAY + 1);
    localparam int HOLD_W = $clog2(SET_HOLD + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [RPT_W-1:0]  RPT_FIRE  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0]  RPT_RELD  = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SET_HOLD);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    logic mode_level_unused, mode_press;
    logic inc_level, inc_press, dec_level, dec_press;

    button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_mode (
        .clk(clk), .reset(reset), .btn(btn_mode), .level(mode_level_unused), .press(mode_press)
    );
    button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_inc (
        .clk(clk), .reset(reset), .btn(btn_inc), .level(inc_level), .press(inc_press)
    );
    button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_dec (
        .clk(clk), .reset(reset), .btn(btn_dec), .level(dec_level), .press(dec_press)
    );

    state_t            state_q, state_d;
    logic [HRS_W-1:0]  hrs_q, hrs_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic              set_q, set_d;
    logic              edit_hrs_q, edit_hrs_d;
    logic              edit_min_q, edit_min_d;
    logic [RPT_W-1:0]  rpt_inc_q, rpt_inc_d, rpt_dec_q, rpt_dec_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              editing, inc_fire, dec_fire, inc_step, dec_step;
    logic              any_press, timed_out;

    assign editing   = (state_q == EDIT_HRS) || (state_q == EDIT_MIN);
    assign inc_fire  = inc_level && (rpt_inc_q == RPT_FIRE);
    assign dec_fire  = dec_level && (rpt_dec_q == RPT_FIRE);
    assign inc_step  = editing && (inc_press || inc_fire);
    assign dec_step  = editing && (dec_press || dec_fire);
    assign any_press = mode_press || inc_press || dec_press;
    assign timed_out = !any_press && (tmo_q == TMO_LAST);

    // Auto-repeat: after the first fire the counter reloads so later fires are REPEAT_PERIOD apart.
    always_comb begin
        rpt_inc_d = '0;
        rpt_dec_d = '0;
        if (editing && inc_level)
            rpt_inc_d = inc_fire ? RPT_RELD : rpt_inc_q + 1'b1;
        if (editing && dec_level)
            rpt_dec_d = dec_fire ? RPT_RELD : rpt_dec_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        hrs_d   = hrs_q;
        min_d   = min_q;
        set_d   = 1'b0;
        hold_d  = '0;
        tmo_d   = '0;
        if (editing && !any_press && (tmo_q != TMO_LAST))
            tmo_d = tmo_q + 1'b1;
        case (state_q)
            RUN: begin
                if (mode_press) begin
                    hrs_d   = clamp_hours(cur_hours);
                    min_d   = clamp_minutes(cur_minutes);
                    state_d = EDIT_HRS;
                end
            end
            EDIT_HRS: begin
                hrs_d = step_hours(hrs_q, inc_step, dec_step);
                if (mode_press)
                    state_d = EDIT_MIN;
                else if (timed_out)
                    state_d = RUN;
            end
            EDIT_MIN: begin
                min_d = step_minutes(min_q, inc_step, dec_step);
                if (mode_press)
                    state_d = COMMIT;
                else if (timed_out)
                    state_d = RUN;
            end
            COMMIT: begin
                // set rises one clock after entry so the shadow has settled first.
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    set_d  = 1'b1;
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        edit_hrs_d = (state_d == EDIT_HRS);
        edit_min_d = (state_d == EDIT_MIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            hrs_q      <= '0;
            min_q      <= '0;
            set_q      <= 1'b0;
            edit_hrs_q <= 1'b0;
            edit_min_q <= 1'b0;
            rpt_inc_q  <= '0;
            rpt_dec_q  <= '0;
            hold_q     <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            hrs_q      <= hrs_d;
            min_q      <= min_d;
            set_q      <= set_d;
            edit_hrs_q <= edit_hrs_d;
            edit_min_q <= edit_min_d;
            rpt_inc_q  <= rpt_inc_d;
            rpt_dec_q  <= rpt_dec_d;
            hold_q     <= hold_d;
            tmo_q      <= tmo_d;
        end
    end

    assign set         = set_q;
    assign set_hours   = hrs_q;
    assign set_minutes = min_q;
    assign edit_hrs    = edit_hrs_q;
    assign edit_min    = edit_min_q;

endmodule
